// File: rtl/log2_arbiter.sv
// log2_arbiter: round-robin front end that shares one pipelined log2 unit
// among NREQ requesters. Each accepted operand carries a tag through a
// LAT-deep shadow pipeline, so the result returning from the datapath can be
// matched to its requester and parked in a small in-order result FIFO.
// Issue is credit-limited, so a result can never arrive to a full buffer.

module log2_arbiter #(
    parameter int NREQ       = 4,
    parameter int LAT        = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [24*NREQ-1:0]      req_data,
    output logic [23:0]             lg_din,
    input  logic [7:0]              lg_dout,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [7:0]              rsp_data,
    output logic                    rsp_err,
    output logic                    busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int IFW = $clog2(LAT + 1);

    // Operands below 1.0 (raw value 0x000100) have a negative or undefined
    // log2 and are flagged as errors instead of being reported.
    localparam logic [23:0] MIN_OPERAND = 24'h000100;

    // ------------------------------------------------------------------
    // Arbitration state
    // ------------------------------------------------------------------
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] grant_id;
    logic           grant_found;
    logic           can_issue;
    logic           issue;
    logic           issue_err;

    // ------------------------------------------------------------------
    // Tag pipeline that shadows the external log2 datapath
    // ------------------------------------------------------------------
    logic [LAT-1:0] tag_v;
    logic [LAT-1:0] tag_err;
    logic [IDW-1:0] tag_id [LAT];
    logic [IFW-1:0] inflight;

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    logic [IDW-1:0] mem_id   [FIFO_DEPTH];
    logic [7:0]     mem_data [FIFO_DEPTH];
    logic           mem_err  [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  fifo_count;
    logic           fifo_full;
    logic           wr_en;
    logic           pop;

    // Round-robin search: the requester after the last granted one is looked
    // at first, wrapping around so every requester is eventually reached.
    always_comb begin
        int idx;
        grant_id    = '0;
        grant_found = 1'b0;
        idx         = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

    // Count live tags; together with the FIFO occupancy this is the number
    // of buffer slots already promised to earlier issues.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + IFW'(tag_v[i]);
        end
    end

    // Issue only while every outstanding result is guaranteed a FIFO slot;
    // reset forces the request side quiet.
    always_comb begin
        can_issue = 1'b0;
        if (!rst && ((int'(inflight) + int'(fifo_count)) < FIFO_DEPTH)) begin
            can_issue = 1'b1;
        end
        issue = can_issue && grant_found;
    end

    // Drive the handshake and datapath operand for the winning requester;
    // the operand bus idles at zero when nothing is accepted.
    always_comb begin
        req_ready = '0;
        lg_din    = 24'h000000;
        issue_err = 1'b0;
        if (issue) begin
            req_ready[grant_id] = 1'b1;
            lg_din              = req_data[24*int'(grant_id) +: 24];
            issue_err           = (req_data[24*int'(grant_id) +: 24] < MIN_OPERAND);
        end
    end

    // Priority pointer moves only on a completed handshake, so a requester
    // that withdraws before being served does not disturb the rotation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= IDW'(NREQ - 1);
        end else if (issue) begin
            last_grant <= grant_id;
        end
    end

    // Tag shift register: stage 0 is loaded on issue and the last stage lines
    // up with the datapath result for that same operand.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v   <= '0;
            tag_err <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_v[0]   <= issue;
            tag_err[0] <= issue_err;
            tag_id[0]  <= grant_id;
            for (int i = 1; i < LAT; i++) begin
                tag_v[i]   <= tag_v[i-1];
                tag_err[i] <= tag_err[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
        end
    end

    // FIFO control: a result with a live tag is captured; untagged datapath
    // output (for example stale data after a reset) is simply ignored.
    always_comb begin
        fifo_full = (fifo_count == CW'(FIFO_DEPTH));
        rsp_valid = (fifo_count != '0);
        pop       = rsp_valid && rsp_ready;
        wr_en     = tag_v[LAT-1] && (!fifo_full || pop);
    end

    // Storage array has no reset; empty entries are masked at the outputs.
    // Error results are stored as zero so garbage from the datapath never
    // escapes.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_id[wr_ptr]   <= tag_id[LAT-1];
            mem_err[wr_ptr]  <= tag_err[LAT-1];
            mem_data[wr_ptr] <= tag_err[LAT-1] ? 8'h00 : lg_dout;
        end
    end

    // Pointers wrap explicitly at FIFO_DEPTH; a simultaneous write and pop
    // leaves the occupancy unchanged even when the buffer is full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Head-of-queue outputs read straight from storage, so they hold steady
    // until popped; they read as zero whenever the FIFO is empty.
    always_comb begin
        rsp_id   = '0;
        rsp_data = 8'h00;
        rsp_err  = 1'b0;
        if (rsp_valid) begin
            rsp_id   = mem_id[rd_ptr];
            rsp_data = mem_data[rd_ptr];
            rsp_err  = mem_err[rd_ptr];
        end
        busy = (tag_v != '0) || rsp_valid;
    end

endmodule

// File: tb/tb_log2_arbiter.sv
// tb_log2_arbiter: directed bench for log2_arbiter with a behavioural
// three-stage log2 datapath that answers with hand-computed values.

module tb_log2_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [95:0]  req_data;
    logic [23:0]  lg_din;
    logic [7:0]   lg_dout;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [7:0]   rsp_data;
    logic         rsp_err;
    logic         busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [23:0] opnd  [4] = '{24'h000200, 24'h000100, 24'hFFFFFF, 24'h000300};
    logic [7:0]  lgtab [4] = '{8'h10, 8'h00, 8'hFF, 8'h19};
    int          firstIds [4] = '{3, 0, 1, 3};

    logic [7:0] pipe [3];

    log2_arbiter #(.NREQ(4), .LAT(3), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .lg_din    (lg_din),
        .lg_dout   (lg_dout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Hand-computed log2 results in {int[3:0], frac[3:0]}; out-of-range
    // operands return junk so forced-zero error data is visible.
    function automatic logic [7:0] lgModel(input logic [23:0] x);
        case (x)
            24'h000100: return 8'h00;
            24'h000200: return 8'h10;
            24'h000300: return 8'h19;
            24'hFFFFFF: return 8'hFF;
            24'h0000FF: return 8'hAA;
            24'h000000: return 8'hAA;
            default:    return 8'h5A;
        endcase
    endfunction

    // Three-cycle datapath: operand captured on the issue edge, result
    // presented during the cycle before the third following edge.
    always @(posedge clk) begin
        pipe[0] <= lgModel(lg_din);
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
    end
    assign lg_dout = pipe[2];

    // Time-limit guard so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic ready);
        req_valid = valid;
        rsp_ready = ready;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic waitResponse(input logic [1:0] id, input logic [7:0] data, input logic err);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            #1;
            if (rsp_valid) found = 1'b1;
            else tick();
        end
        checkOutput("rsp_seen", found, 1);
        if (found) begin
            checkOutput("rsp_id", rsp_id, id);
            checkOutput("rsp_data", rsp_data, data);
            checkOutput("rsp_err", rsp_err, err);
            tick();
        end
    endtask

    initial begin
        int g, r, hs, e, seen;
        logic [3:0] firstReady;

        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_data  = {opnd[3], opnd[2], opnd[1], opnd[0]};

        // Reset state, with requests present to show they are held off.
        tick();
        applyStimulus(4'b1111, 1'b1);
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_lg_din", lg_din, 0);
        checkOutput("rst_rsp_id", rsp_id, 0);
        checkOutput("rst_rsp_data", rsp_data, 0);
        checkOutput("rst_rsp_err", rsp_err, 0);
        applyStimulus(4'b0000, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // Single request: operand 3.0, result 0x19 four cycles later.
        req_data[23:0] = 24'h000300;
        applyStimulus(4'b0001, 1'b1);
        checkOutput("single_grant", req_ready, 4'b0001);
        checkOutput("single_din", lg_din, 24'h000300);
        tick();
        applyStimulus(4'b0000, 1'b1);
        checkOutput("single_lat1", rsp_valid, 0);
        tick(); #1;
        checkOutput("single_lat2", rsp_valid, 0);
        tick(); #1;
        checkOutput("single_lat3", rsp_valid, 0);
        tick(); #1;
        checkOutput("single_valid", rsp_valid, 1);
        checkOutput("single_id", rsp_id, 0);
        checkOutput("single_data", rsp_data, 8'h19);
        checkOutput("single_err", rsp_err, 0);
        tick(); #1;
        checkOutput("single_popped", rsp_valid, 0);
        checkOutput("single_idle", busy, 0);

        // Fresh reset so rotation starts at requester 0 again.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_data[23:0] = opnd[0];
        tick();

        // Round robin with all four requesters continuously valid.
        applyStimulus(4'b1111, 1'b1);
        g = 0;
        r = 0;
        for (int cyc = 0; cyc < 60 && (g < 8 || r < 8); cyc++) begin
            if (g >= 8) req_valid = '0;
            #1;
            if (req_ready != 0 && g < 8) begin
                checkOutput("rr_grant", req_ready, 4'b0001 << (g % 4));
                checkOutput("rr_din", lg_din, opnd[g % 4]);
                g++;
            end
            if (rsp_valid) begin
                checkOutput("rr_id", rsp_id, r % 4);
                checkOutput("rr_data", rsp_data, lgtab[r % 4]);
                r++;
            end
            tick();
        end
        checkOutput("rr_grants", g, 8);
        checkOutput("rr_rsps", r, 8);

        // Out-of-range operands report an error with zero data.
        req_data[47:24] = 24'h0000FF;
        applyStimulus(4'b0010, 1'b1);
        checkOutput("oor_grant", req_ready, 4'b0010);
        tick();
        applyStimulus(4'b0000, 1'b1);
        waitResponse(2'd1, 8'h00, 1'b1);
        req_data[47:24] = 24'h000000;
        applyStimulus(4'b0010, 1'b1);
        checkOutput("zero_grant", req_ready, 4'b0010);
        tick();
        applyStimulus(4'b0000, 1'b1);
        waitResponse(2'd1, 8'h00, 1'b1);
        req_data[47:24] = opnd[1];

        // Backpressure: exactly FIFO_DEPTH handshakes, then stall.
        applyStimulus(4'b1111, 1'b0);
        hs = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if ((req_valid & req_ready) != 0) hs++;
            tick();
        end
        #1;
        checkOutput("bp_handshakes", hs, 4);
        checkOutput("bp_stalled", req_ready, 0);
        checkOutput("bp_head_id", rsp_id, 2);

        // One pop frees one slot; requester 2 withdraws first, so the next
        // grant must skip it and go to requester 3.
        applyStimulus(4'b1011, 1'b1);
        checkOutput("bp_pop_data", rsp_data, 8'hFF);
        hs = 0;
        firstReady = '0;
        for (int i = 0; i < 10; i++) begin
            if (i == 1) rsp_ready = 1'b0;
            #1;
            if (req_ready != 0) begin
                if (hs == 0) firstReady = req_ready;
                hs++;
            end
            tick();
        end
        checkOutput("bp_one_more", hs, 1);
        checkOutput("bp_skip_dropped", firstReady, 4'b1000);

        // Head must hold while the consumer stalls.
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("hold_id", rsp_id, 3);
            checkOutput("hold_data", rsp_data, 8'h19);
            tick();
        end

        // Stream through many pointer wraps and drain, order preserved.
        applyStimulus(4'b1111, 1'b1);
        r = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (r >= 12) req_valid = '0;
            #1;
            if (rsp_valid) begin
                e = (r < 4) ? firstIds[r] : ((r - 4) % 4);
                checkOutput("stream_id", rsp_id, e);
                checkOutput("stream_data", rsp_data, lgtab[e]);
                r++;
            end
            if (r >= 12 && !busy) break;
            tick();
        end
        checkOutput("stream_enough", (r >= 12), 1);
        checkOutput("stream_drained", busy, 0);
        tick();

        // Reset with two results buffered and two tags in flight.
        applyStimulus(4'b0001, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("pre_rst_issue", req_ready, 4'b0001);
            tick();
        end
        applyStimulus(4'b0000, 1'b0);
        tick();
        #1;
        checkOutput("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", rsp_valid, 0);
        checkOutput("mid_rst_busy", busy, 0);
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (rsp_valid) seen++;
            tick();
        end
        checkOutput("post_rst_silent", seen, 0);
        checkOutput("post_rst_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
